// File: rtl/imem_fetch.sv
// Instruction-fetch initiator for registered-address instruction memories.
// Pairs each returned word with its PC and buffers it across decode stalls.
module imem_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] accept_cnt
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] accept_cnt_q, accept_cnt_d;

  logic        slot_valid;
  logic        accept;
  logic        advance;
  logic [31:0] redir_pc;
  logic        unused_redir_lsb;

  assign redir_pc         = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lsb = &{1'b0, redirect_pc[1:0]};

  assign slot_valid = resp_valid_q | hold_valid_q;
  assign out_valid  = slot_valid & ~redirect_valid;
  assign out_inst   = hold_valid_q ? hold_inst_q : imem_inst;
  assign out_pc     = resp_pc_q;
  assign imem_addr  = redirect_valid ? redirect_pc[31:2]
                                     : fetch_pc_q[31:2];
  assign accept_cnt = accept_cnt_q;

  assign accept  = out_valid & ~stall;
  assign advance = ~redirect_valid & (~slot_valid | ~stall);

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    hold_inst_d  = hold_inst_q;
    hold_valid_d = hold_valid_q;
    accept_cnt_d = accept_cnt_q + {31'b0, accept};
    unique case (1'b1)
      redirect_valid: begin
        fetch_pc_d   = redir_pc + 32'd4;
        resp_pc_d    = redir_pc;
        resp_valid_d = 1'b1;
        hold_valid_d = 1'b0;
      end
      advance: begin
        fetch_pc_d   = fetch_pc_q + 32'd4;
        resp_pc_d    = fetch_pc_q;
        resp_valid_d = 1'b1;
        hold_valid_d = 1'b0;
      end
      default: begin
        // Capture only the first stalled cycle; memory then refetches
        // the successor so it is ready when the stall drops.
        if (!hold_valid_q) begin
          hold_inst_d  = imem_inst;
          hold_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      resp_valid_q <= 1'b0;
      hold_inst_q  <= 32'h0;
      hold_valid_q <= 1'b0;
      accept_cnt_q <= 32'h0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      hold_inst_q  <= hold_inst_d;
      hold_valid_q <= hold_valid_d;
      accept_cnt_q <= accept_cnt_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Testbench for imem_fetch: directed scenarios plus random stall/redirect
// traffic checked against an instruction-stream reference model.
module tb_imem_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [29:0] imem_addr;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] accept_cnt;

  imem_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .accept_cnt     (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'hA000_0000 + {2'b00, a};
  endfunction

  // Memory: address registered every edge, data returned next cycle.
  logic [29:0] maddr_q;
  always @(posedge clk) maddr_q <= imem_addr;
  assign imem_inst = mem_word(maddr_q);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the instruction that should occupy the decode slot.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = RESET_PC;
    m_cnt   = 32'h0;
  endtask

  task automatic step(input logic st, input logic rv,
                      input logic [31:0] rp);
    logic        ev;
    logic [31:0] ea;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    @(negedge clk);
    ev = m_valid & ~rv;
    check("out_valid", {31'b0, out_valid}, {31'b0, ev});
    if (ev) begin
      check("out_pc", out_pc, m_pc);
      check("out_inst", out_inst, mem_word(m_pc[31:2]));
    end
    if (rv)           ea = rp;
    else if (m_valid) ea = m_pc + 32'd4;
    else              ea = RESET_PC;
    check("imem_addr", {2'b00, imem_addr}, {2'b00, ea[31:2]});
    check("accept_cnt", accept_cnt, m_cnt);
    if (rv) begin
      m_valid = 1'b1;
      m_pc    = {rp[31:2], 2'b00};
    end else if (!m_valid) begin
      m_valid = 1'b1;
      m_pc    = RESET_PC;
    end else if (!st) begin
      m_cnt = m_cnt + 32'd1;
      m_pc  = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
    check({tag, "_pc"}, out_pc, RESET_PC);
    check({tag, "_addr"}, {2'b00, imem_addr}, {2'b00, RESET_PC[31:2]});
    check({tag, "_cnt"}, accept_cnt, 32'h0);
  endtask

  initial begin
    logic [31:0] tgt;
    int          guard;
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    #12;
    check_reset_outs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Free run through eight accepts.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'h0);
    check("cnt8", accept_cnt, 32'd8);

    // Re-reset so the slot lands on pc 8 for the stall scenario.
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    guard = 0;
    while (!(m_valid && m_pc == 32'h8) && guard < 20) begin
      step(1'b0, 1'b0, 32'h0);
      guard++;
    end
    check("reach_pc8", m_pc, 32'h8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("after_stall_pc", out_pc, 32'h10);

    // Redirect to a misaligned target while pc 16 is presented.
    step(1'b0, 1'b1, 32'h0000_0042);
    check("redir_pc", out_pc, 32'h40);
    check("redir_inst", out_inst, 32'hA000_0010);
    step(1'b0, 1'b0, 32'h0);

    // Redirect together with stall during a stall.
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Back-to-back redirects.
    step(1'b0, 1'b1, 32'h0000_1000);
    step(1'b0, 1'b1, 32'h0000_2000);
    step(1'b0, 1'b0, 32'h0);

    // Wrap of the PC at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0)
        tgt = 32'hFFFF_FFF0 | {28'b0, tgt[3:0]};
      step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, tgt);
    end

    // Async reset asserted mid-stall, between edges.
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("arst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
